// File: rtl/panda_risc_v_fu_res_collector.sv
// Result collector: buffers results from FU_N execution units in per-channel
// FIFOs and merges them onto one write-back port with round-robin arbitration.
//
// Handshake semantics (all ports): a transfer happens on a rising aclk edge
// where valid and ready are both high. A source may not withdraw or change a
// pending m_wb payload; this block holds grant and payload stable while
// m_wb_vld is high and m_wb_ready is low (the "lock"). s_fu_res_ready depends
// only on registered FIFO fill, never on s_fu_res_vld.
module panda_risc_v_fu_res_collector #(
    parameter int  FU_N           = 5,
    parameter int  IBUS_TID_WIDTH = 8,
    parameter int  FIFO_DEPTH     = 4,
    parameter real SIM_DELAY      = 1
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [FU_N-1:0]                       s_fu_res_vld,
    input  logic [FU_N*IBUS_TID_WIDTH-1:0]        s_fu_res_tid,
    input  logic [FU_N*32-1:0]                    s_fu_res_data,
    input  logic [FU_N*3-1:0]                     s_fu_res_err,
    output logic [FU_N-1:0]                       s_fu_res_ready,
    output logic                                  m_wb_vld,
    input  logic                                  m_wb_ready,
    output logic [IBUS_TID_WIDTH-1:0]             m_wb_tid,
    output logic [31:0]                           m_wb_data,
    output logic [2:0]                            m_wb_err,
    output logic [((FU_N > 2) ? $clog2(FU_N) : 1)-1:0] m_wb_fu_id,
    input  logic                                  flush,
    output logic                                  collector_idle
);

    localparam int FU_ID_W = (FU_N > 2) ? $clog2(FU_N) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    // Per-channel storage and bookkeeping
    logic [IBUS_TID_WIDTH-1:0] tid_mem  [FU_N][FIFO_DEPTH];
    logic [31:0]               data_mem [FU_N][FIFO_DEPTH];
    logic [2:0]                err_mem  [FU_N][FIFO_DEPTH];
    logic [AW-1:0]             wptr     [FU_N];
    logic [AW-1:0]             rptr     [FU_N];
    logic [CW-1:0]             cnt      [FU_N];

    logic [FU_N-1:0]    full;
    logic [FU_N-1:0]    nonempty;
    logic [FU_N-1:0]    push;
    logic [FU_N-1:0]    pop;
    logic               hs;

    // Arbiter state: rr_ptr is where the next search starts; lock/lock_id
    // freeze the grant while the write-back sink is stalling.
    logic [FU_ID_W-1:0] rr_ptr;
    logic [FU_ID_W-1:0] rr_grant;
    logic [FU_ID_W-1:0] grant;
    logic [FU_ID_W-1:0] grant_next_rr;
    logic               lock;
    logic [FU_ID_W-1:0] lock_id;

    // Channel status decoded from registered counts; flush blocks pushes
    always_comb begin
        full     = '0;
        nonempty = '0;
        push     = '0;
        for (int i = 0; i < FU_N; i++) begin
            full[i]     = (cnt[i] == CW'(FIFO_DEPTH));
            nonempty[i] = (cnt[i] != '0);
            push[i]     = s_fu_res_vld[i] & ~full[i] & ~flush;
        end
    end

    assign s_fu_res_ready = ~full;
    assign m_wb_vld       = |nonempty;
    assign collector_idle = ~(|nonempty);
    assign hs             = m_wb_vld & m_wb_ready & ~flush;

    // Round-robin search from rr_ptr; a held lock overrides the search
    always_comb begin
        int idx;
        logic found;
        rr_grant = rr_ptr;
        found    = 1'b0;
        for (int k = 0; k < FU_N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= FU_N) idx = idx - FU_N;
            if (!found && nonempty[idx]) begin
                found    = 1'b1;
                rr_grant = FU_ID_W'(idx);
            end
        end
        grant = lock ? lock_id : rr_grant;
        grant_next_rr = (grant == FU_ID_W'(FU_N - 1)) ? '0 : grant + 1'b1;
    end

    // Only the granted channel pops, and only on a real handshake
    always_comb begin
        pop = '0;
        for (int i = 0; i < FU_N; i++) begin
            pop[i] = hs && (grant == FU_ID_W'(i));
        end
    end

    // FIFO pointers and counts; flush empties every channel in one edge
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < FU_N; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < FU_N; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < FU_N; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + 1'b1;
                if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Entry storage: written on push, no reset needed (guarded by counts)
    always_ff @(posedge aclk) begin
        for (int i = 0; i < FU_N; i++) begin
            if (push[i]) begin
                tid_mem[i][wptr[i]]  <= s_fu_res_tid[i*IBUS_TID_WIDTH +: IBUS_TID_WIDTH];
                data_mem[i][wptr[i]] <= s_fu_res_data[i*32 +: 32];
                err_mem[i][wptr[i]]  <= s_fu_res_err[i*3 +: 3];
            end
        end
    end

    // Round-robin pointer advance and stall lock
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr  <= '0;
            lock    <= 1'b0;
            lock_id <= '0;
        end else if (flush) begin
            lock    <= 1'b0;
        end else if (hs) begin
            rr_ptr  <= grant_next_rr;
            lock    <= 1'b0;
        end else if (m_wb_vld) begin
            lock    <= 1'b1;
            lock_id <= grant;
        end
    end

    assign m_wb_fu_id = grant;
    assign m_wb_tid   = tid_mem[grant][rptr[grant]];
    assign m_wb_data  = data_mem[grant][rptr[grant]];
    assign m_wb_err   = err_mem[grant][rptr[grant]];

endmodule

// File: tb/tb_panda_risc_v_fu_res_collector.sv
// Bench for the result collector: directed scenarios plus random traffic,
// all compared against a queue-based model of the collector's rules.
module tb_panda_risc_v_fu_res_collector;

    localparam int FU_N  = 5;
    localparam int TW    = 8;
    localparam int DEPTH = 4;
    localparam int FW    = 3;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [FU_N-1:0]      s_fu_res_vld;
    logic [FU_N*TW-1:0]   s_fu_res_tid;
    logic [FU_N*32-1:0]   s_fu_res_data;
    logic [FU_N*3-1:0]    s_fu_res_err;
    logic [FU_N-1:0]      s_fu_res_ready;
    logic                 m_wb_vld;
    logic                 m_wb_ready;
    logic [TW-1:0]        m_wb_tid;
    logic [31:0]          m_wb_data;
    logic [2:0]           m_wb_err;
    logic [FW-1:0]        m_wb_fu_id;
    logic                 flush;
    logic                 collector_idle;

    panda_risc_v_fu_res_collector #(
        .FU_N(FU_N), .IBUS_TID_WIDTH(TW), .FIFO_DEPTH(DEPTH), .SIM_DELAY(1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_fu_res_vld(s_fu_res_vld), .s_fu_res_tid(s_fu_res_tid),
        .s_fu_res_data(s_fu_res_data), .s_fu_res_err(s_fu_res_err),
        .s_fu_res_ready(s_fu_res_ready),
        .m_wb_vld(m_wb_vld), .m_wb_ready(m_wb_ready),
        .m_wb_tid(m_wb_tid), .m_wb_data(m_wb_data), .m_wb_err(m_wb_err),
        .m_wb_fu_id(m_wb_fu_id), .flush(flush), .collector_idle(collector_idle)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [TW-1:0] tid;
        logic [31:0]   data;
        logic [2:0]    err;
    } ent_t;

    ent_t q [FU_N][$];
    int   m_rr;
    bit   m_lock;
    int   m_lock_g;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_grant();
        int idx;
        if (m_lock) return m_lock_g;
        for (int k = 0; k < FU_N; k++) begin
            idx = (m_rr + k) % FU_N;
            if (q[idx].size() > 0) return idx;
        end
        return -1;
    endfunction

    function automatic bit m_empty();
        for (int i = 0; i < FU_N; i++) if (q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear(input bit keep_rr);
        for (int i = 0; i < FU_N; i++) q[i].delete();
        m_lock = 1'b0;
        if (!keep_rr) m_rr = 0;
    endtask

    // Compare all DUT outputs against the model's current (registered) view
    task automatic compare_outputs();
        logic [FU_N-1:0] er;
        int g;
        for (int i = 0; i < FU_N; i++) er[i] = (q[i].size() < DEPTH);
        check("ready", 64'(s_fu_res_ready), 64'(er));
        g = m_grant();
        check("vld", 64'(m_wb_vld), 64'(g >= 0));
        check("idle", 64'(collector_idle), 64'(m_empty()));
        if (g >= 0) begin
            check("fu_id", 64'(m_wb_fu_id), 64'(g));
            check("tid", 64'(m_wb_tid), 64'(q[g][0].tid));
            check("data", 64'(m_wb_data), 64'(q[g][0].data));
            check("err", 64'(m_wb_err), 64'(q[g][0].err));
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied
    task automatic model_step();
        bit acc [FU_N];
        int g;
        ent_t e;
        for (int i = 0; i < FU_N; i++) acc[i] = s_fu_res_vld[i] && (q[i].size() < DEPTH);
        if (flush) begin
            model_clear(1'b1);
            return;
        end
        g = m_grant();
        if (g >= 0) begin
            if (m_wb_ready) begin
                void'(q[g].pop_front());
                m_rr   = (g + 1) % FU_N;
                m_lock = 1'b0;
            end else begin
                m_lock   = 1'b1;
                m_lock_g = g;
            end
        end
        for (int i = 0; i < FU_N; i++) begin
            if (acc[i]) begin
                e.tid  = s_fu_res_tid[i*TW +: TW];
                e.data = s_fu_res_data[i*32 +: 32];
                e.err  = s_fu_res_err[i*3 +: 3];
                q[i].push_back(e);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        s_fu_res_vld  = '0;
        s_fu_res_tid  = '0;
        s_fu_res_data = '0;
        s_fu_res_err  = '0;
        flush         = 1'b0;
    endtask

    task automatic set_push(input int ch, input logic [TW-1:0] tid);
        s_fu_res_vld[ch]            = 1'b1;
        s_fu_res_tid[ch*TW +: TW]   = tid;
        s_fu_res_data[ch*32 +: 32]  = $urandom;
        s_fu_res_err[ch*3 +: 3]     = 3'($urandom_range(0, 7));
    endtask

    // Called at a falling edge with inputs applied: check, step model, advance
    task automatic tick();
        #1;
        compare_outputs();
        model_step();
        @(negedge aclk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        m_wb_ready = 1'b0;
        model_clear(1'b0);

        // reset state
        repeat (2) @(negedge aclk);
        #1;
        check("rst_vld", 64'(m_wb_vld), 64'd0);
        check("rst_idle", 64'(collector_idle), 64'd1);
        check("rst_ready", 64'(s_fu_res_ready), 64'h1f);
        @(negedge aclk);
        aresetn = 1'b1;

        // two channels pushed together drain in index order
        m_wb_ready = 1'b1;
        set_push(0, 8'h11);
        set_push(3, 8'h33);
        tick();
        clear_inputs();
        #1;
        check("d32_id0", 64'(m_wb_fu_id), 64'd0);
        check("d32_tid0", 64'(m_wb_tid), 64'h11);
        tick();
        #1;
        check("d32_id3", 64'(m_wb_fu_id), 64'd3);
        check("d32_tid3", 64'(m_wb_tid), 64'h33);
        tick();
        tick();

        // stalled output stays locked on ch2 while ch0 becomes non-empty
        m_wb_ready = 1'b0;
        set_push(2, 8'h22);
        tick();
        clear_inputs();
        set_push(0, 8'hA0);
        tick();
        clear_inputs();
        repeat (3) tick();
        #1;
        check("d33_lock_id", 64'(m_wb_fu_id), 64'd2);
        check("d33_lock_tid", 64'(m_wb_tid), 64'h22);
        m_wb_ready = 1'b1;
        tick();
        #1;
        check("d33_next_id", 64'(m_wb_fu_id), 64'd0);
        tick();
        tick();

        // fill ch1 beyond depth while stalled, then drain in order
        m_wb_ready = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            clear_inputs();
            set_push(1, 8'(t));
            tick();
        end
        clear_inputs();
        #1;
        check("d34_full", 64'(s_fu_res_ready[1]), 64'd0);
        m_wb_ready = 1'b1;
        repeat (6) tick();

        // all channels kept busy: strict rotation
        for (int c = 0; c < 16; c++) begin
            clear_inputs();
            for (int i = 0; i < FU_N; i++) set_push(i, 8'($urandom_range(0, 255)));
            tick();
        end
        clear_inputs();
        repeat (24) tick();

        // flush with three channels loaded and a concurrent push
        m_wb_ready = 1'b0;
        set_push(0, 8'h01);
        set_push(2, 8'h02);
        set_push(4, 8'h04);
        tick();
        tick();
        clear_inputs();
        set_push(1, 8'h99);
        flush = 1'b1;
        tick();
        clear_inputs();
        #1;
        check("d36_vld", 64'(m_wb_vld), 64'd0);
        check("d36_idle", 64'(collector_idle), 64'd1);
        check("d36_ready", 64'(s_fu_res_ready), 64'h1f);
        tick();

        // asynchronous reset with entries buffered
        set_push(0, 8'h51);
        set_push(1, 8'h52);
        set_push(2, 8'h53);
        tick();
        clear_inputs();
        aresetn = 1'b0;
        #1;
        check("d37_vld", 64'(m_wb_vld), 64'd0);
        check("d37_idle", 64'(collector_idle), 64'd1);
        check("d37_ready", 64'(s_fu_res_ready), 64'h1f);
        model_clear(1'b0);
        #1;
        aresetn = 1'b1;
        m_wb_ready = 1'b1;
        set_push(3, 8'h61);
        tick();
        clear_inputs();
        repeat (3) tick();

        // random traffic in phases of differing sink pressure
        for (int ph = 0; ph < 6; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 60 : 95);
            for (int c = 0; c < 300; c++) begin
                clear_inputs();
                for (int i = 0; i < FU_N; i++)
                    if ($urandom_range(0, 99) < 35) set_push(i, 8'($urandom_range(0, 255)));
                m_wb_ready = ($urandom_range(0, 99) < rdy_pct);
                flush      = ($urandom_range(0, 99) < 2);
                tick();
            end
        end
        clear_inputs();
        m_wb_ready = 1'b1;
        repeat (30) tick();
        #1;
        check("final_idle", 64'(collector_idle), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
